axi4_sram_slave: RTL and testbench

//  AXI4 slave memory model on the accelerator shell's mem_* master port, directly downstream of the RRM.

---
 rtl/axi4_sram_slave.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_axi4_sram_slave.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_sram_slave
//  Description : AXI4 slave memory model. Byte-strobed, word-organised array
//                with independent write (AW/W/B) and read (AR/R) engines,
//                each carrying one burst at a time. FIXED, INCR and WRAP
//                bursts; SLVERR for illegal bursts and out-of-window beats.
//  Ports       : clk, rst (async, active high)
//                mem_aw_*  write address channel   (valid/ready, id/addr/len/
//                                                   size/burst, lock/cache/
//                                                   prot/qos ignored)
//                mem_w_*   write data channel      (data/strb/last)
//                mem_b_*   write response channel  (id/resp)
//                mem_ar_*  read address channel    (as AW)
//                mem_r_*   read data channel       (id/data/resp/last)
//  Revision    : 1.0  initial release
// ============================================================================
module axi4_sram_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8,
    parameter int DEPTH      = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    // write address
    input  logic                    mem_aw_valid,
    output logic                    mem_aw_ready,
    input  logic [ID_WIDTH-1:0]     mem_aw_bits_id,
    input  logic [ADDR_WIDTH-1:0]   mem_aw_bits_addr,
    input  logic [7:0]              mem_aw_bits_len,
    input  logic [2:0]              mem_aw_bits_size,
    input  logic [1:0]              mem_aw_bits_burst,
    input  logic                    mem_aw_bits_lock,
    input  logic [3:0]              mem_aw_bits_cache,
    input  logic [2:0]              mem_aw_bits_prot,
    input  logic [3:0]              mem_aw_bits_qos,
    // write data
    input  logic                    mem_w_valid,
    output logic                    mem_w_ready,
    input  logic [DATA_WIDTH-1:0]   mem_w_bits_data,
    input  logic [DATA_WIDTH/8-1:0] mem_w_bits_strb,
    input  logic                    mem_w_bits_last,
    // write response
    output logic                    mem_b_valid,
    input  logic                    mem_b_ready,
    output logic [ID_WIDTH-1:0]     mem_b_bits_id,
    output logic [1:0]              mem_b_bits_resp,
    // read address
    input  logic                    mem_ar_valid,
    output logic                    mem_ar_ready,
    input  logic [ID_WIDTH-1:0]     mem_ar_bits_id,
    input  logic [ADDR_WIDTH-1:0]   mem_ar_bits_addr,
    input  logic [7:0]              mem_ar_bits_len,
    input  logic [2:0]              mem_ar_bits_size,
    input  logic [1:0]              mem_ar_bits_burst,
    input  logic                    mem_ar_bits_lock,
    input  logic [3:0]              mem_ar_bits_cache,
    input  logic [2:0]              mem_ar_bits_prot,
    input  logic [3:0]              mem_ar_bits_qos,
    // read data
    output logic                    mem_r_valid,
    input  logic                    mem_r_ready,
    output logic [ID_WIDTH-1:0]     mem_r_bits_id,
    output logic [DATA_WIDTH-1:0]   mem_r_bits_data,
    output logic [1:0]              mem_r_bits_resp,
    output logic                    mem_r_bits_last
);

    localparam int c_NBYTES = DATA_WIDTH / 8;
    localparam int c_LSB    = $clog2(c_NBYTES);
    localparam int c_IDXW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // ------------------------------------------------------------------------
    // Burst helpers
    // ------------------------------------------------------------------------
    function automatic logic [ADDR_WIDTH-1:0] f_next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] incr;
        logic [ADDR_WIDTH-1:0] mask;
        incr = ADDR_WIDTH'(1) << size;
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst)
            2'b01:   f_next_addr = addr + incr;
            2'b10:   f_next_addr = (addr & ~mask) | ((addr + incr) & mask);
            default: f_next_addr = addr;
        endcase
    endfunction

    // A burst that can never be serviced: reserved type, beat wider than
    // the bus, or WRAP with a length AXI does not allow.
    function automatic logic f_bad(
        input logic [7:0] len,
        input logic [2:0] size,
        input logic [1:0] burst
    );
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        f_bad = (burst == 2'b11) || (int'(size) > c_LSB) ||
                ((burst == 2'b10) && !wrap_len_ok);
    endfunction

    function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] idx;
        idx = addr >> c_LSB;
        f_in_range = (64'(idx) < 64'(DEPTH));
    endfunction

    // ------------------------------------------------------------------------
    // Storage (not reset)
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // ------------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------------
    w_state_t              r_w_state;
    w_state_t              w_w_state_nxt;
    logic [ID_WIDTH-1:0]   r_aw_id;
    logic [ADDR_WIDTH-1:0] r_aw_addr;
    logic [7:0]            r_aw_len;
    logic [2:0]            r_aw_size;
    logic [1:0]            r_aw_burst;
    logic                  r_aw_bad;
    logic [7:0]            r_w_cnt;
    logic                  r_w_err;

    logic                  w_aw_fire;
    logic                  w_w_fire;
    logic                  w_w_last;
    logic                  w_wr_in_range;
    logic                  w_mem_we;
    logic [c_IDXW-1:0]     w_wr_idx;

    assign w_aw_fire     = mem_aw_valid && mem_aw_ready;
    assign w_w_fire      = mem_w_valid && mem_w_ready;
    // Beat count, not wlast, decides where the burst ends.
    assign w_w_last      = (r_w_cnt == r_aw_len);
    assign w_wr_in_range = f_in_range(r_aw_addr);
    assign w_wr_idx      = c_IDXW'(r_aw_addr >> c_LSB);
    assign w_mem_we      = w_w_fire && !r_aw_bad && w_wr_in_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w_state <= W_IDLE;
        end else begin
            r_w_state <= w_w_state_nxt;
        end
    end

    always_comb begin
        w_w_state_nxt = r_w_state;
        mem_aw_ready  = 1'b0;
        mem_w_ready   = 1'b0;
        mem_b_valid   = 1'b0;
        case (r_w_state)
            W_IDLE: begin
                mem_aw_ready = 1'b1;
                if (mem_aw_valid) w_w_state_nxt = W_DATA;
            end
            W_DATA: begin
                mem_w_ready = 1'b1;
                if (mem_w_valid && w_w_last) w_w_state_nxt = W_RESP;
            end
            W_RESP: begin
                mem_b_valid = 1'b1;
                if (mem_b_ready) w_w_state_nxt = W_IDLE;
            end
            default: w_w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aw_id    <= '0;
            r_aw_addr  <= '0;
            r_aw_len   <= '0;
            r_aw_size  <= '0;
            r_aw_burst <= '0;
            r_aw_bad   <= 1'b0;
            r_w_cnt    <= '0;
            r_w_err    <= 1'b0;
        end else if (w_aw_fire) begin
            r_aw_id    <= mem_aw_bits_id;
            r_aw_addr  <= mem_aw_bits_addr;
            r_aw_len   <= mem_aw_bits_len;
            r_aw_size  <= mem_aw_bits_size;
            r_aw_burst <= mem_aw_bits_burst;
            r_aw_bad   <= f_bad(mem_aw_bits_len, mem_aw_bits_size, mem_aw_bits_burst);
            // An illegal burst is an error from the start; otherwise clean.
            r_w_err    <= f_bad(mem_aw_bits_len, mem_aw_bits_size, mem_aw_bits_burst);
            r_w_cnt    <= '0;
        end else if (w_w_fire) begin
            r_w_cnt   <= r_w_cnt + 8'd1;
            r_aw_addr <= f_next_addr(r_aw_addr, r_aw_len, r_aw_size, r_aw_burst);
            if ((!r_aw_bad && !w_wr_in_range) || (mem_w_bits_last != w_w_last)) begin
                r_w_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < c_NBYTES; b++) begin
                if (mem_w_bits_strb[b]) begin
                    r_mem[w_wr_idx][8*b +: 8] <= mem_w_bits_data[8*b +: 8];
                end
            end
        end
    end

    assign mem_b_bits_id   = r_aw_id;
    assign mem_b_bits_resp = (mem_b_valid && r_w_err) ? 2'b10 : 2'b00;

    // ------------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------------
    r_state_t              r_r_state;
    r_state_t              w_r_state_nxt;
    logic [ID_WIDTH-1:0]   r_ar_id;
    logic [ADDR_WIDTH-1:0] r_ar_addr;
    logic [7:0]            r_ar_len;
    logic [2:0]            r_ar_size;
    logic [1:0]            r_ar_burst;
    logic                  r_ar_bad;
    logic [7:0]            r_r_cnt;

    logic                  w_ar_fire;
    logic                  w_r_fire;
    logic                  w_r_last;
    logic                  w_rd_ok;
    logic [c_IDXW-1:0]     w_rd_idx;

    assign w_ar_fire = mem_ar_valid && mem_ar_ready;
    assign w_r_fire  = mem_r_valid && mem_r_ready;
    assign w_r_last  = (r_r_cnt == r_ar_len);
    assign w_rd_ok   = !r_ar_bad && f_in_range(r_ar_addr);
    assign w_rd_idx  = c_IDXW'(r_ar_addr >> c_LSB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r_state <= R_IDLE;
        end else begin
            r_r_state <= w_r_state_nxt;
        end
    end

    always_comb begin
        w_r_state_nxt = r_r_state;
        mem_ar_ready  = 1'b0;
        mem_r_valid   = 1'b0;
        case (r_r_state)
            R_IDLE: begin
                mem_ar_ready = 1'b1;
                if (mem_ar_valid) w_r_state_nxt = R_DATA;
            end
            R_DATA: begin
                mem_r_valid = 1'b1;
                if (mem_r_ready && w_r_last) w_r_state_nxt = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ar_id    <= '0;
            r_ar_addr  <= '0;
            r_ar_len   <= '0;
            r_ar_size  <= '0;
            r_ar_burst <= '0;
            r_ar_bad   <= 1'b0;
            r_r_cnt    <= '0;
        end else if (w_ar_fire) begin
            r_ar_id    <= mem_ar_bits_id;
            r_ar_addr  <= mem_ar_bits_addr;
            r_ar_len   <= mem_ar_bits_len;
            r_ar_size  <= mem_ar_bits_size;
            r_ar_burst <= mem_ar_bits_burst;
            r_ar_bad   <= f_bad(mem_ar_bits_len, mem_ar_bits_size, mem_ar_bits_burst);
            r_r_cnt    <= '0;
        end else if (w_r_fire) begin
            r_r_cnt   <= r_r_cnt + 8'd1;
            r_ar_addr <= f_next_addr(r_ar_addr, r_ar_len, r_ar_size, r_ar_burst);
        end
    end

    // Read data is taken straight from the array, so a write landing on the
    // same word in the same cycle is seen only on the following cycle.
    assign mem_r_bits_data = (mem_r_valid && w_rd_ok) ? r_mem[w_rd_idx] : '0;
    assign mem_r_bits_resp = (mem_r_valid && !w_rd_ok) ? 2'b10 : 2'b00;
    assign mem_r_bits_last = mem_r_valid && w_r_last;
    assign mem_r_bits_id   = r_ar_id;

    // Sideband qualifiers carry no meaning for this memory.
    logic w_unused;
    assign w_unused = ^{mem_aw_bits_lock, mem_aw_bits_cache, mem_aw_bits_prot, mem_aw_bits_qos,
                        mem_ar_bits_lock, mem_ar_bits_cache, mem_ar_bits_prot, mem_ar_bits_qos};

endmodule
`default_nettype wire

// File: tb/tb_axi4_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi4_sram_slave
//  Description : Self-checking bench for axi4_sram_slave. Directed table of
//                bursts, hand-written multi-cycle corner cases and a random
//                phase, all checked against a byte-level memory model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi4_sram_slave;

    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int IW    = 8;
    localparam int DEPTH = 1024;
    localparam int NB    = DW / 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           mem_aw_valid, mem_aw_ready;
    logic [IW-1:0]  mem_aw_bits_id;
    logic [AW-1:0]  mem_aw_bits_addr;
    logic [7:0]     mem_aw_bits_len;
    logic [2:0]     mem_aw_bits_size;
    logic [1:0]     mem_aw_bits_burst;
    logic           mem_aw_bits_lock;
    logic [3:0]     mem_aw_bits_cache;
    logic [2:0]     mem_aw_bits_prot;
    logic [3:0]     mem_aw_bits_qos;
    logic           mem_w_valid, mem_w_ready;
    logic [DW-1:0]  mem_w_bits_data;
    logic [NB-1:0]  mem_w_bits_strb;
    logic           mem_w_bits_last;
    logic           mem_b_valid, mem_b_ready;
    logic [IW-1:0]  mem_b_bits_id;
    logic [1:0]     mem_b_bits_resp;
    logic           mem_ar_valid, mem_ar_ready;
    logic [IW-1:0]  mem_ar_bits_id;
    logic [AW-1:0]  mem_ar_bits_addr;
    logic [7:0]     mem_ar_bits_len;
    logic [2:0]     mem_ar_bits_size;
    logic [1:0]     mem_ar_bits_burst;
    logic           mem_ar_bits_lock;
    logic [3:0]     mem_ar_bits_cache;
    logic [2:0]     mem_ar_bits_prot;
    logic [3:0]     mem_ar_bits_qos;
    logic           mem_r_valid, mem_r_ready;
    logic [IW-1:0]  mem_r_bits_id;
    logic [DW-1:0]  mem_r_bits_data;
    logic [1:0]     mem_r_bits_resp;
    logic           mem_r_bits_last;

    axi4_sram_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .mem_aw_valid(mem_aw_valid), .mem_aw_ready(mem_aw_ready),
        .mem_aw_bits_id(mem_aw_bits_id), .mem_aw_bits_addr(mem_aw_bits_addr),
        .mem_aw_bits_len(mem_aw_bits_len), .mem_aw_bits_size(mem_aw_bits_size),
        .mem_aw_bits_burst(mem_aw_bits_burst), .mem_aw_bits_lock(mem_aw_bits_lock),
        .mem_aw_bits_cache(mem_aw_bits_cache), .mem_aw_bits_prot(mem_aw_bits_prot),
        .mem_aw_bits_qos(mem_aw_bits_qos),
        .mem_w_valid(mem_w_valid), .mem_w_ready(mem_w_ready),
        .mem_w_bits_data(mem_w_bits_data), .mem_w_bits_strb(mem_w_bits_strb),
        .mem_w_bits_last(mem_w_bits_last),
        .mem_b_valid(mem_b_valid), .mem_b_ready(mem_b_ready),
        .mem_b_bits_id(mem_b_bits_id), .mem_b_bits_resp(mem_b_bits_resp),
        .mem_ar_valid(mem_ar_valid), .mem_ar_ready(mem_ar_ready),
        .mem_ar_bits_id(mem_ar_bits_id), .mem_ar_bits_addr(mem_ar_bits_addr),
        .mem_ar_bits_len(mem_ar_bits_len), .mem_ar_bits_size(mem_ar_bits_size),
        .mem_ar_bits_burst(mem_ar_bits_burst), .mem_ar_bits_lock(mem_ar_bits_lock),
        .mem_ar_bits_cache(mem_ar_bits_cache), .mem_ar_bits_prot(mem_ar_bits_prot),
        .mem_ar_bits_qos(mem_ar_bits_qos),
        .mem_r_valid(mem_r_valid), .mem_r_ready(mem_r_ready),
        .mem_r_bits_id(mem_r_bits_id), .mem_r_bits_data(mem_r_bits_data),
        .mem_r_bits_resp(mem_r_bits_resp), .mem_r_bits_last(mem_r_bits_last)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] m_mem [DEPTH];     // reference memory contents
    logic [DW-1:0] g_wd  [256];       // write data for the next burst
    logic [NB-1:0] g_ws  [256];       // write strobes for the next burst
    logic [DW-1:0] g_rd  [256];       // data captured from the last read

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_bad(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        if (burst == 2'b11) return 1'b1;
        if (int'(size) > 2) return 1'b1;
        if (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
        return 1'b0;
    endfunction

    // Byte address of beat i: wrap bursts live in an aligned window of
    // (len+1)*beat_bytes bytes; incrementing bursts roll over 16 bits.
    function automatic logic [15:0] m_addr(input logic [15:0] start, input logic [7:0] len,
                                           input logic [2:0] size, input logic [1:0] burst, input int i);
        int incr;
        int total;
        int base;
        incr  = 1 << size;
        total = (int'(len) + 1) * incr;
        case (burst)
            2'b00:   return start;
            2'b01:   return 16'(int'(start) + i * incr);
            default: begin
                base = (int'(start) / total) * total;
                return 16'(base + ((int'(start) % total) + i * incr) % total);
            end
        endcase
    endfunction

    function automatic bit m_oor(input logic [15:0] a);
        return int'(a >> 2) >= DEPTH;
    endfunction

    // ---------------- bus tasks ----------------
    task automatic do_write(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit last_err,
                            input int bhold, input bit gaps, output logic [1:0] bresp);
        bit bad;
        bit err;
        int n;
        logic [15:0] a;
        bresp = 2'bxx;
        bad = m_bad(len, size, burst);
        err = bad || last_err;
        if (!bad) for (int i = 0; i <= int'(len); i++) if (m_oor(m_addr(addr, len, size, burst, i))) err = 1'b1;

        mem_aw_valid = 1'b1; mem_aw_bits_id = id; mem_aw_bits_addr = addr;
        mem_aw_bits_len = len; mem_aw_bits_size = size; mem_aw_bits_burst = burst;
        mem_aw_bits_lock = 1'($urandom); mem_aw_bits_cache = 4'($urandom);
        mem_aw_bits_prot = 3'($urandom); mem_aw_bits_qos = 4'($urandom);
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_aw_ready && n < 200);
        if (!mem_aw_ready) begin chk("aw_ready_timeout", 0, 1); mem_aw_valid = 1'b0; return; end
        @(posedge clk); #1;
        mem_aw_valid = 1'b0;
        chk("w_ready_latency", 64'(mem_w_ready), 1);

        for (int i = 0; i <= int'(len); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
            mem_w_valid = 1'b1;
            mem_w_bits_data = g_wd[i];
            mem_w_bits_strb = g_ws[i];
            mem_w_bits_last = (i == int'(len)) ^ (last_err && i == 0);
            n = 0;
            do begin @(negedge clk); n++; end while (!mem_w_ready && n < 200);
            if (!mem_w_ready) begin chk("w_ready_timeout", 0, 1); mem_w_valid = 1'b0; return; end
            @(posedge clk); #1;
            mem_w_valid = 1'b0;
        end
        chk("b_valid_latency", 64'(mem_b_valid), 1);
        for (int k = 0; k < bhold; k++) begin
            @(negedge clk);
            chk("b_hold_valid", 64'(mem_b_valid), 1);
            chk("b_hold_aw_ready", 64'(mem_aw_ready), 0);
        end
        mem_b_ready = 1'b1;
        #1;
        chk("b_valid", 64'(mem_b_valid), 1);
        chk("b_id", 64'(mem_b_bits_id), 64'(id));
        chk("b_resp", 64'(mem_b_bits_resp), err ? 64'h2 : 64'h0);
        bresp = mem_b_bits_resp;
        @(posedge clk); #1;
        mem_b_ready = 1'b0;
        chk("b_done_valid", 64'(mem_b_valid), 0);
        chk("b_done_aw_ready", 64'(mem_aw_ready), 1);

        if (!bad) begin
            for (int i = 0; i <= int'(len); i++) begin
                a = m_addr(addr, len, size, burst, i);
                if (!m_oor(a))
                    for (int b = 0; b < NB; b++)
                        if (g_ws[i][b]) m_mem[int'(a >> 2)][8*b +: 8] = g_wd[i][8*b +: 8];
            end
        end
    endtask

    task automatic do_read(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit rand_rdy,
                           input int stall_beat);
        logic [DW-1:0] ed [256];
        logic [1:0]    er [256];
        logic [15:0]   a;
        bit bad;
        bit stalled;
        bit alive;
        int stall_left;
        int beat;
        int n;
        bad = m_bad(len, size, burst);
        for (int i = 0; i <= int'(len); i++) begin
            a = m_addr(addr, len, size, burst, i);
            if (bad || m_oor(a)) begin ed[i] = '0; er[i] = 2'b10; end
            else begin ed[i] = m_mem[int'(a >> 2)]; er[i] = 2'b00; end
        end

        mem_ar_valid = 1'b1; mem_ar_bits_id = id; mem_ar_bits_addr = addr;
        mem_ar_bits_len = len; mem_ar_bits_size = size; mem_ar_bits_burst = burst;
        mem_ar_bits_lock = 1'($urandom); mem_ar_bits_cache = 4'($urandom);
        mem_ar_bits_prot = 3'($urandom); mem_ar_bits_qos = 4'($urandom);
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_ar_ready && n < 200);
        if (!mem_ar_ready) begin chk("ar_ready_timeout", 0, 1); mem_ar_valid = 1'b0; return; end
        @(posedge clk); #1;
        mem_ar_valid = 1'b0;
        chk("r_valid_latency", 64'(mem_r_valid), 1);

        beat = 0; n = 0; stalled = 0; stall_left = 0; alive = 1;
        while (alive && beat <= int'(len) && n < 3000) begin
            if (beat == stall_beat && !stalled) begin stalled = 1; stall_left = 3; end
            if (stall_left > 0) begin mem_r_ready = 1'b0; stall_left--; end
            else mem_r_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk); n++;
            chk("r_valid", 64'(mem_r_valid), 1);
            if (!mem_r_valid) alive = 0;
            chk("r_data", 64'(mem_r_bits_data), 64'(ed[beat]));
            chk("r_resp", 64'(mem_r_bits_resp), 64'(er[beat]));
            chk("r_last", 64'(mem_r_bits_last), (beat == int'(len)) ? 64'd1 : 64'd0);
            chk("r_id", 64'(mem_r_bits_id), 64'(id));
            g_rd[beat] = mem_r_bits_data;
            if (mem_r_ready) beat++;
            @(posedge clk); #1;
        end
        if (n >= 3000) chk("r_timeout", 0, 1);
        mem_r_ready = 1'b0;
        chk("r_end_valid", 64'(mem_r_valid), 0);
        chk("r_end_ar_ready", 64'(mem_ar_ready), 1);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [7:0]  id;
        logic [15:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [1:0]  exp_bresp;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] br;
        logic [15:0] ra;
        logic [7:0]  rl;
        logic [2:0]  rs;
        logic [1:0]  rb;

        tbl[0]  = '{8'h05, 16'h0010, 8'd3, 3'd2, 2'b01, 2'b00};
        tbl[1]  = '{8'h21, 16'h0040, 8'd2, 3'd2, 2'b00, 2'b00};
        tbl[2]  = '{8'h33, 16'h0018, 8'd3, 3'd2, 2'b10, 2'b00};
        tbl[3]  = '{8'h44, 16'h1000, 8'd0, 3'd2, 2'b01, 2'b10};
        tbl[4]  = '{8'h55, 16'h0080, 8'd1, 3'd2, 2'b11, 2'b10};
        tbl[5]  = '{8'h66, 16'h0090, 8'd0, 3'd3, 2'b01, 2'b10};
        tbl[6]  = '{8'h77, 16'h00A0, 8'd2, 3'd2, 2'b10, 2'b10};
        tbl[7]  = '{8'h88, 16'h0FFC, 8'd1, 3'd2, 2'b01, 2'b10};
        tbl[8]  = '{8'h99, 16'h0101, 8'd3, 3'd0, 2'b01, 2'b00};
        tbl[9]  = '{8'hAB, 16'h0FF4, 8'd7, 3'd2, 2'b10, 2'b00};
        tbl[10] = '{8'hBB, 16'hFFFC, 8'd1, 3'd2, 2'b01, 2'b10};

        rst = 1'b1;
        mem_aw_valid = 0; mem_aw_bits_id = 0; mem_aw_bits_addr = 0; mem_aw_bits_len = 0;
        mem_aw_bits_size = 0; mem_aw_bits_burst = 0; mem_aw_bits_lock = 0; mem_aw_bits_cache = 0;
        mem_aw_bits_prot = 0; mem_aw_bits_qos = 0;
        mem_w_valid = 0; mem_w_bits_data = 0; mem_w_bits_strb = 0; mem_w_bits_last = 0;
        mem_b_ready = 0;
        mem_ar_valid = 0; mem_ar_bits_id = 0; mem_ar_bits_addr = 0; mem_ar_bits_len = 0;
        mem_ar_bits_size = 0; mem_ar_bits_burst = 0; mem_ar_bits_lock = 0; mem_ar_bits_cache = 0;
        mem_ar_bits_prot = 0; mem_ar_bits_qos = 0;
        mem_r_ready = 0;

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_aw_ready", 64'(mem_aw_ready), 1);
        chk("rst_ar_ready", 64'(mem_ar_ready), 1);
        chk("rst_w_ready", 64'(mem_w_ready), 0);
        chk("rst_b_valid", 64'(mem_b_valid), 0);
        chk("rst_r_valid", 64'(mem_r_valid), 0);
        chk("rst_b_bits", 64'({mem_b_bits_id, mem_b_bits_resp}), 0);
        chk("rst_r_bits", 64'({mem_r_bits_id, mem_r_bits_resp, mem_r_bits_last}), 0);
        chk("rst_r_data", 64'(mem_r_bits_data), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // fill the whole window so every model word is known
        for (int q = 0; q < 4; q++) begin
            for (int i = 0; i < 256; i++) begin g_wd[i] = $urandom; g_ws[i] = 4'hF; end
            do_write(8'(q), 16'(q * 1024), 8'd255, 3'd2, 2'b01, 1'b0, 0, 1'b0, br);
        end
        do_read(8'h0E, 16'h0000, 8'd255, 3'd2, 2'b01, 1'b0, -1);

        // table: write each burst, check bresp, read back the same and as INCR
        for (int t = 0; t < 11; t++) begin
            for (int i = 0; i < 256; i++) begin g_wd[i] = $urandom; g_ws[i] = 4'hF; end
            if (t == 0) for (int i = 0; i < 4; i++) g_wd[i] = 32'h11111111 * (i + 1);
            do_write(tbl[t].id, tbl[t].addr, tbl[t].len, tbl[t].size, tbl[t].burst, 1'b0, 0, 1'b0, br);
            chk("tbl_bresp", 64'(br), 64'(tbl[t].exp_bresp));
            do_read(tbl[t].id, tbl[t].addr, tbl[t].len, tbl[t].size, tbl[t].burst, 1'b0, -1);
            do_read(8'hC3, tbl[t].addr, tbl[t].len, 3'd2, 2'b01, 1'b0, -1);
            if (t == 0)
                for (int i = 0; i < 4; i++) chk("incr_data", 64'(g_rd[i]), 64'(32'h11111111 * (i + 1)));
        end

        // byte strobes merge into the existing word
        g_wd[0] = 32'h11223344; g_ws[0] = 4'hF;
        do_write(8'h01, 16'h0020, 8'd0, 3'd2, 2'b01, 1'b0, 0, 1'b0, br);
        g_wd[0] = 32'hAABBCCDD; g_ws[0] = 4'b0101;
        do_write(8'h02, 16'h0020, 8'd0, 3'd2, 2'b01, 1'b0, 0, 1'b0, br);
        do_read(8'h03, 16'h0020, 8'd0, 3'd2, 2'b01, 1'b0, -1);
        chk("strb_merge", 64'(g_rd[0]), 64'h11BB33DD);

        // wrap ordering starting mid-window
        g_wd[0] = 32'hA0A0A0A0; g_wd[1] = 32'hB1B1B1B1; g_wd[2] = 32'hC2C2C2C2; g_wd[3] = 32'hD3D3D3D3;
        for (int i = 0; i < 4; i++) g_ws[i] = 4'hF;
        do_write(8'h10, 16'h0018, 8'd3, 3'd2, 2'b10, 1'b0, 0, 1'b0, br);
        do_read(8'h11, 16'h0010, 8'd3, 3'd2, 2'b01, 1'b0, -1);
        chk("wrap_0x10", 64'(g_rd[0]), 64'hC2C2C2C2);
        chk("wrap_0x14", 64'(g_rd[1]), 64'hD3D3D3D3);
        chk("wrap_0x18", 64'(g_rd[2]), 64'hA0A0A0A0);
        chk("wrap_0x1C", 64'(g_rd[3]), 64'hB1B1B1B1);

        // wlast mismatch: write lands, response is SLVERR
        for (int i = 0; i < 2; i++) begin g_wd[i] = $urandom; g_ws[i] = 4'hF; end
        do_write(8'h12, 16'h0300, 8'd1, 3'd2, 2'b01, 1'b1, 0, 1'b0, br);
        do_read(8'h13, 16'h0300, 8'd1, 3'd2, 2'b01, 1'b0, -1);

        // r_ready stall mid-burst, b_ready held off
        do_read(8'h20, 16'h0010, 8'd3, 3'd2, 2'b01, 1'b0, 1);
        g_wd[0] = $urandom; g_ws[0] = 4'hF;
        do_write(8'h21, 16'h0340, 8'd0, 3'd2, 2'b01, 1'b0, 5, 1'b0, br);

        // simultaneous AW/AR to the same word: read sees the old value
        g_wd[0] = ~m_mem[16'h0380 >> 2]; g_ws[0] = 4'hF;
        fork
            do_write(8'h30, 16'h0380, 8'd0, 3'd2, 2'b01, 1'b0, 0, 1'b0, br);
            do_read(8'h31, 16'h0380, 8'd0, 3'd2, 2'b01, 1'b0, -1);
        join
        do_read(8'h32, 16'h0380, 8'd0, 3'd2, 2'b01, 1'b0, -1);

        // reset after two beats of a four-beat write
        mem_aw_valid = 1'b1; mem_aw_bits_id = 8'h40; mem_aw_bits_addr = 16'h0200;
        mem_aw_bits_len = 8'd3; mem_aw_bits_size = 3'd2; mem_aw_bits_burst = 2'b01;
        @(negedge clk);
        chk("rstmid_aw_ready", 64'(mem_aw_ready), 1);
        @(posedge clk); #1;
        mem_aw_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            g_wd[i] = $urandom;
            mem_w_valid = 1'b1; mem_w_bits_data = g_wd[i]; mem_w_bits_strb = 4'hF; mem_w_bits_last = 1'b0;
            @(negedge clk);
            chk("rstmid_w_ready", 64'(mem_w_ready), 1);
            @(posedge clk); #1;
            m_mem[(16'h0200 >> 2) + i] = g_wd[i];
        end
        rst = 1'b1;
        mem_w_valid = 1'b0;
        #1;
        chk("rstmid_w_ready_drop", 64'(mem_w_ready), 0);
        chk("rstmid_b_valid", 64'(mem_b_valid), 0);
        chk("rstmid_r_valid", 64'(mem_r_valid), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_aw_ready_after", 64'(mem_aw_ready), 1);
        chk("rstmid_w_ready_after", 64'(mem_w_ready), 0);
        @(posedge clk); #1;
        do_read(8'h41, 16'h0200, 8'd1, 3'd2, 2'b01, 1'b0, -1);

        // random phase
        for (int it = 0; it < 80; it++) begin
            rb = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            rs = ($urandom_range(0, 19) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            if (rb == 2'b10) begin
                case ($urandom_range(0, 4))
                    0: rl = 8'd1; 1: rl = 8'd3; 2: rl = 8'd7; 3: rl = 8'd15; default: rl = 8'd2;
                endcase
            end else rl = 8'($urandom_range(0, 15));
            case ($urandom_range(0, 9))
                0:       ra = 16'($urandom);
                1, 2:    ra = 16'($urandom_range(16'h0F00, 16'h10FF));
                default: ra = 16'($urandom_range(0, 16'h0FFF));
            endcase
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < 256; i++) begin g_wd[i] = $urandom; g_ws[i] = 4'($urandom); end
                do_write(8'($urandom), ra, rl, rs, rb, ($urandom_range(0, 9) == 0), $urandom_range(0, 2), 1'b1, br);
            end else begin
                do_read(8'($urandom), ra, rl, rs, rb, 1'b1, -1);
            end
        end
        do_read(8'h7F, 16'h0000, 8'd255, 3'd2, 2'b01, 1'b1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
